// File: rtl/menu_pkg.sv
// Shared encodings for the main-menu navigation controller: menu states,
// fixed item indices of the shipped menu and exit-dialog selection values.
package menu_pkg;

    typedef enum logic [1:0] {
        MENU_MAIN    = 2'd0,
        MENU_PAGE    = 2'd1,
        MENU_CONFIRM = 2'd2
    } menu_state_e;

    localparam int ITEM_START   = 0;
    localparam int ITEM_CONTROL = 1;
    localparam int ITEM_ABOUT   = 2;
    localparam int ITEM_EXIT    = 3;

    localparam logic SEL_YES = 1'b0;
    localparam logic SEL_NO  = 1'b1;

    // Saturating or wrapping step of a menu index; dir_up = 1 moves towards 0.
    function automatic int step_index(input int idx, input int n_items,
                                      input bit dir_up, input bit wrap);
        int res;
        res = idx;
        if (dir_up) begin
            if (idx == 0) res = wrap ? n_items - 1 : 0;
            else          res = idx - 1;
        end else begin
            if (idx == n_items - 1) res = wrap ? 0 : n_items - 1;
            else                    res = idx + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/key_event.sv
// Turns a key level into one-cycle events: a press edge, plus optional
// hold-to-repeat timed by a down-counter that fires on terminal count 1.
module key_event #(
    parameter bit          REPEAT_EN = 1'b0,
    parameter logic [31:0] REP_DELAY = 32'd32_500_000,
    parameter logic [31:0] REP_RATE  = 32'd6_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    input  logic clr,
    output logic key_ev
);

    logic        hist_q, hist_d;
    logic [31:0] cnt_q, cnt_d;
    logic        press;

    always_comb begin
        press  = key & ~hist_q;
        hist_d = key;
        cnt_d  = cnt_q;
        key_ev = press;
        if (REPEAT_EN) begin
            // cnt_q holds the edges remaining until the next repeat; 0 = idle
            if (clr || !key) begin
                cnt_d = '0;
            end else if (press) begin
                cnt_d = REP_DELAY;
            end else if (cnt_q == 32'd1) begin
                cnt_d  = REP_RATE;
                key_ev = 1'b1;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 32'd1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/menu_nav_ctrl.sv
// Main-menu navigation FSM: cursor movement, page entry/return and the
// exit confirmation dialog, driven by debounced key events.
//
//   state        | meaning
//   MENU_MAIN    | main menu shown, cursor moves over the items
//   MENU_PAGE    | sub-page page_id shown (STICKY_ITEM page ignores keys)
//   MENU_CONFIRM | yes/no exit dialog, confirm_sel highlights the choice
module menu_nav_ctrl
    import menu_pkg::*;
#(
    parameter int          N_ITEMS      = 4,
    parameter int          CUR_W        = 2,
    parameter int          WRAP         = 0,
    parameter int          STICKY_ITEM  = ITEM_START,
    parameter int          CONFIRM_ITEM = ITEM_EXIT,
    parameter logic [31:0] REP_DELAY    = 32'd32_500_000,
    parameter logic [31:0] REP_RATE     = 32'd6_500_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_up,
    input  logic             key_down,
    input  logic             key_enter,
    input  logic             key_back,
    input  logic             back_to_main,
    output logic [1:0]       menu_state,
    output logic [CUR_W-1:0] cursor,
    output logic [CUR_W-1:0] page_id,
    output logic             confirm_sel,
    output logic             exit_req
);

    localparam logic [CUR_W-1:0] CONFIRM_IDX = CUR_W'(CONFIRM_ITEM);
    localparam logic [CUR_W-1:0] STICKY_IDX  = CUR_W'(STICKY_ITEM);

    logic up_ev, down_ev, enter_ev, back_ev;
    logic nav_up, nav_down;

    menu_state_e      state_q, state_d;
    logic [CUR_W-1:0] cursor_q, cursor_d;
    logic [CUR_W-1:0] page_q, page_d;
    logic             sel_q, sel_d;
    logic             exit_q, exit_d;

    key_event #(.REPEAT_EN(1'b1), .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) u_key_up (
        .clk    (clk),
        .rst    (rst),
        .key    (key_up),
        .clr    (back_to_main),
        .key_ev (up_ev)
    );

    key_event #(.REPEAT_EN(1'b1), .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) u_key_down (
        .clk    (clk),
        .rst    (rst),
        .key    (key_down),
        .clr    (back_to_main),
        .key_ev (down_ev)
    );

    key_event #(.REPEAT_EN(1'b0), .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) u_key_enter (
        .clk    (clk),
        .rst    (rst),
        .key    (key_enter),
        .clr    (back_to_main),
        .key_ev (enter_ev)
    );

    key_event #(.REPEAT_EN(1'b0), .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) u_key_back (
        .clk    (clk),
        .rst    (rst),
        .key    (key_back),
        .clr    (back_to_main),
        .key_ev (back_ev)
    );

    // Simultaneous up and down cancel out; enter is then free to act.
    assign nav_up   = up_ev & ~down_ev;
    assign nav_down = down_ev & ~up_ev;

    always_comb begin
        state_d  = state_q;
        cursor_d = (int'(cursor_q) >= N_ITEMS) ? '0 : cursor_q;
        page_d   = page_q;
        sel_d    = sel_q;
        exit_d   = 1'b0;

        if (back_to_main) begin
            state_d  = MENU_MAIN;
            cursor_d = '0;
            sel_d    = SEL_NO;
        end else begin
            case (state_q)
                MENU_MAIN: begin
                    if (back_ev) begin
                        state_d = MENU_MAIN;
                    end else if (nav_up || nav_down) begin
                        cursor_d = CUR_W'(step_index(int'(cursor_d), N_ITEMS,
                                                     nav_up, WRAP != 0));
                    end else if (enter_ev) begin
                        if (cursor_d == CONFIRM_IDX) begin
                            state_d = MENU_CONFIRM;
                            sel_d   = SEL_NO;
                        end else begin
                            state_d = MENU_PAGE;
                            page_d  = cursor_d;
                        end
                    end
                end
                MENU_PAGE: begin
                    if (page_q != STICKY_IDX && (back_ev || enter_ev)) begin
                        state_d = MENU_MAIN;
                    end
                end
                MENU_CONFIRM: begin
                    if (back_ev) begin
                        state_d  = MENU_MAIN;
                        cursor_d = CONFIRM_IDX;
                        sel_d    = SEL_NO;
                    end else if (nav_up) begin
                        sel_d = SEL_YES;
                    end else if (nav_down) begin
                        sel_d = SEL_NO;
                    end else if (enter_ev) begin
                        if (sel_q == SEL_YES) begin
                            exit_d = 1'b1;
                        end else begin
                            state_d  = MENU_MAIN;
                            cursor_d = CONFIRM_IDX;
                            sel_d    = SEL_NO;
                        end
                    end
                end
                default: begin
                    state_d  = MENU_MAIN;
                    cursor_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MENU_MAIN;
            cursor_q <= '0;
            page_q   <= '0;
            sel_q    <= SEL_NO;
            exit_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            page_q   <= page_d;
            sel_q    <= sel_d;
            exit_q   <= exit_d;
        end
    end

    assign menu_state  = state_q;
    assign cursor      = cursor_q;
    assign page_id     = page_q;
    assign confirm_sel = sel_q;
    assign exit_req    = exit_q;

endmodule
